// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: round-robin digit select, blanked one-hot enables, double-buffered digits.
// Latency: enables/digit are combinational from registers; en drop darkens display after 1 edge; loads shown at next frame boundary.
// Backpressure: none; load is a fire-and-forget strobe, newest pending load before a frame boundary wins.
module seg_scan_ctrl #(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic [3:0] d,
    input  logic       load,
    output logic [1:0] sel,
    output logic [3:0] digit,
    output logic       en_a,
    output logic       en_b,
    output logic       en_c,
    output logic       en_d,
    output logic       frame_done,
    output logic       pend_valid
);

    // Counter width covers 0..DIV-1; DIV>=2 keeps this at least one bit.
    localparam int            CW      = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    sel_nxt;
    logic [3:0]    act       [4];
    logic [3:0]    pend      [4];
    logic [3:0]    load_vals [4];
    logic          slot_end;
    logic          frame_end;
    logic          lit;

    // Gather the four incoming digit values so buffers can be copied as a whole.
    always_comb begin
        load_vals[0] = a;
        load_vals[1] = b;
        load_vals[2] = c;
        load_vals[3] = d;
    end

    // Slot and frame boundary detection; a frame ends on the last cycle of digit d while scanning.
    always_comb begin
        slot_end  = (cnt == CNT_MAX);
        frame_end = en && slot_end && (sel == 2'd3);
    end

    // Next slot counter and digit index; idle parks both at zero.
    always_comb begin
        cnt_nxt = cnt;
        sel_nxt = sel;
        if (!en) begin
            cnt_nxt = '0;
            sel_nxt = 2'd0;
        end else if (slot_end) begin
            cnt_nxt = '0;
            sel_nxt = sel + 2'd1;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // Scan position registers and the frame-start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            sel        <= 2'd0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            sel        <= sel_nxt;
            frame_done <= frame_end;
        end
    end

    // Digit buffers: idle loads go straight to the display, scan loads wait for the frame boundary
    // so a half-updated frame is never shown. A load landing on the boundary itself bypasses pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                act[i]  <= 4'd0;
                pend[i] <= 4'd0;
            end
            pend_valid <= 1'b0;
        end else if (!en) begin
            if (load) begin
                act        <= load_vals;
                pend       <= load_vals;
                pend_valid <= 1'b0;
            end
        end else if (frame_end) begin
            if (load) begin
                act  <= load_vals;
                pend <= load_vals;
            end else if (pend_valid) begin
                act  <= pend;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pend       <= load_vals;
            pend_valid <= 1'b1;
        end
    end

    // Enables decode from registered state only; the leading blank cycles of each slot stay dark
    // so the mux can settle on the new digit before its common line turns on.
    always_comb begin
        lit   = (cnt >= BLANK_C);
        en_a  = lit && (sel == 2'd0);
        en_b  = lit && (sel == 2'd1);
        en_c  = lit && (sel == 2'd2);
        en_d  = lit && (sel == 2'd3);
        digit = act[sel];
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en0 = 1'b0;
    logic       en1 = 1'b0;
    logic       load0 = 1'b0;
    logic       load1 = 1'b0;
    logic [3:0] a = 4'd0, b = 4'd0, c = 4'd0, d = 4'd0;

    logic [1:0] sel0, sel1;
    logic [3:0] digit0, digit1;
    logic       en_a0, en_b0, en_c0, en_d0;
    logic       en_a1, en_b1, en_c1, en_d1;
    logic       fd0, fd1, pv0, pv1;
    logic [3:0] ens0, ens1;

    assign ens0 = {en_d0, en_c0, en_b0, en_a0};
    assign ens1 = {en_d1, en_c1, en_b1, en_a1};

    int vectors     = 0;
    int miscompares = 0;

    // Scan-path model for the DIV=4/BLANK=1 instance.
    int          k;
    logic [15:0] shown;
    logic [15:0] pend_m;
    bit          pv_m;

    seg_scan_ctrl #(.DIV(4), .BLANK(1)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .a(a), .b(b), .c(c), .d(d), .load(load0),
        .sel(sel0), .digit(digit0), .en_a(en_a0), .en_b(en_b0), .en_c(en_c0), .en_d(en_d0),
        .frame_done(fd0), .pend_valid(pv0)
    );

    seg_scan_ctrl #(.DIV(5), .BLANK(2)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .a(a), .b(b), .c(c), .d(d), .load(load1),
        .sel(sel1), .digit(digit1), .en_a(en_a1), .en_b(en_b1), .en_c(en_c1), .en_d(en_d1),
        .frame_done(fd1), .pend_valid(pv1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vals(input logic [15:0] v);
        a = v[3:0];
        b = v[7:4];
        c = v[11:8];
        d = v[15:12];
    endtask

    // One scanning cycle of dut0 with optional load, followed by a full output check.
    task automatic scan_step(input bit ld, input logic [15:0] v);
        bit      boundary;
        int      s;
        int      cn;
        logic [3:0] ens_exp;
        boundary = ((k % 16) == 15);
        en0   = 1'b1;
        load0 = ld;
        set_vals(v);
        step();
        load0 = 1'b0;
        k++;
        if (boundary) begin
            if (ld) shown = v;
            else if (pv_m) shown = pend_m;
            pv_m = 1'b0;
        end else if (ld) begin
            pend_m = v;
            pv_m   = 1'b1;
        end
        s  = (k / 4) % 4;
        cn = k % 4;
        ens_exp = (cn >= 1) ? (4'b0001 << s) : 4'b0000;
        chk("scan_sel",   sel0,   s[1:0]);
        chk("scan_en",    ens0,   ens_exp);
        chk("scan_digit", digit0, shown[s*4 +: 4]);
        chk("scan_fd",    fd0,    boundary);
        chk("scan_pv",    pv0,    pv_m);
    endtask

    task automatic scan_run(input int n);
        for (int i = 0; i < n; i++) scan_step(1'b0, 16'h0000);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel"},   sel0,   2'd0);
        chk({tag, "_en"},    ens0,   4'd0);
        chk({tag, "_digit"}, digit0, 4'd0);
        chk({tag, "_fd"},    fd0,    1'b0);
        chk({tag, "_pv"},    pv0,    1'b0);
    endtask

    initial begin
        int         c1;
        int         s1;
        bit         e;
        bit         fd_exp;
        logic [3:0] ens1_exp;

        // Reset state.
        shown = 16'h0; pend_m = 16'h0; pv_m = 1'b0; k = 0;
        step();
        step();
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        step();
        chk_all_zero("post_reset_idle");

        // Idle load goes straight to the active buffer.
        load0 = 1'b1;
        set_vals(16'h4321);
        step();
        load0 = 1'b0;
        shown = 16'h4321;
        chk("idle_load_pv",    pv0,    1'b0);
        chk("idle_load_digit", digit0, 4'd1);
        chk("idle_load_en",    ens0,   4'd0);

        // Two full frames of plain scanning: digits 1,2,3,4, frame_done every 16 cycles.
        k = 0;
        scan_run(32);

        // Atomic update: load 9,8,7,6 while sel=1.
        scan_run(5);                       // k=37: sel=1, cnt=1
        scan_step(1'b1, 16'h6789);         // k=38
        chk("atomic_pv_set",   pv0,    1'b1);
        chk("atomic_digit_b",  digit0, 4'd2);
        scan_run(10);                      // k=48: wrap
        chk("atomic_wrap_digit", digit0, 4'd9);
        chk("atomic_wrap_fd",    fd0,    1'b1);
        chk("atomic_wrap_pv",    pv0,    1'b0);
        scan_run(16);                      // k=64

        // Newest load in a frame wins.
        scan_step(1'b1, 16'h5555);         // k=65
        scan_run(4);
        scan_step(1'b1, 16'h6666);         // k=70
        scan_run(10);                      // k=80: wrap
        chk("newest_wins_digit", digit0, 4'd6);
        scan_run(15);                      // k=95: sel=3, cnt=3

        // Load exactly on the boundary edge.
        scan_step(1'b1, 16'h7777);         // k=96
        chk("boundary_load_digit", digit0, 4'd7);
        chk("boundary_load_fd",    fd0,    1'b1);
        chk("boundary_load_pv",    pv0,    1'b0);
        scan_run(6);

        // Stop: enables dark after one edge.
        en0 = 1'b0;
        step();
        chk("stop_sel", sel0, 2'd0);
        chk("stop_en",  ens0, 4'd0);
        chk("stop_fd",  fd0,  1'b0);
        chk("stop_digit", digit0, 4'd7);

        // Mid-scan asynchronous reset.
        k = 0;
        scan_run(6);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        shown = 16'h0; pend_m = 16'h0; pv_m = 1'b0; k = 0;
        @(negedge clk);
        rst = 1'b0;
        scan_run(20);
        en0 = 1'b0;
        step();

        // Random en/load on the DIV=5, BLANK=2 instance.
        c1 = 0;
        s1 = 0;
        for (int i = 0; i < 1000; i++) begin
            e     = ($urandom_range(0, 3) != 0);
            en1   = e;
            load1 = ($urandom_range(0, 7) == 0);
            set_vals(16'($urandom));
            step();
            if (!e) begin
                c1 = 0;
                s1 = 0;
                fd_exp = 1'b0;
            end else begin
                fd_exp = (c1 == 4) && (s1 == 3);
                if (c1 == 4) begin
                    c1 = 0;
                    s1 = (s1 + 1) % 4;
                end else begin
                    c1++;
                end
            end
            ens1_exp = (c1 >= 2) ? (4'b0001 << s1) : 4'b0000;
            chk("rand_onehot", ($countones(ens1) <= 1), 1'b1);
            chk("rand_en",     ens1, ens1_exp);
            chk("rand_fd",     fd1,  fd_exp);
        end
        en1   = 1'b0;
        load1 = 1'b0;
        step();
        chk("rand_stop_en", ens1, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the 4-digit seven-segment display path. It owns the 4:1 digit mux select and the one-hot digit enables. It holds double-buffered copies of the four 4-bit digit values, so the display changes only on frame boundaries. It rotates round-robin through digits a..d with a programmable dwell and a blanking gap that suppresses ghosting. Its `digit` output feeds the seven-segment decoder; `sel` and `en_a..en_d` drive the mux and the digit common lines.

## Interface
- `DIV`, default 4: cycles per digit slot; legal range 2..65536.
- `BLANK`, default 1: blank cycles at the start of each slot; legal range 1..DIV-1.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `en` input, 1 bit: scan enable; 0 parks the scanner with all digits dark.
- `a`, `b`, `c`, `d` input, 4 bits each: new digit values, sampled only when `load`=1.
- `load` input, 1 bit: single-cycle strobe that captures `a..d` into the pending buffer.
- `sel` output, 2 bits: current digit index (0=a, 1=b, 2=c, 3=d).
- `digit` output, 4 bits: active-buffer value of the digit indexed by `sel`.
- `en_a`, `en_b`, `en_c`, `en_d` output, 1 bit each: one-hot digit enables, active-high.
- `frame_done` output, 1 bit: one-cycle pulse on the first cycle of each new frame.
- `pend_valid` output, 1 bit: pending buffer holds values not yet shown.

## Operation
- **State registers:**
  - `cnt`: width clog2(DIV), range 0..DIV-1.
  - `sel`: 2 bits.
  - `act[4]`: 4 bits each, the active buffer.
  - `pend[4]`: 4 bits each, the pending buffer.
  - `pend_valid` and `frame_done`.
- **Reset:** `cnt`=0, `sel`=0, `act`=all 0, `pend`=all 0, `pend_valid`=0, `frame_done`=0. All enables are 0 and `digit`=0.
- **Idle (`en`=0):**
  - `cnt` and `sel` load 0 synchronously; `frame_done`=0.
  - `load` writes `a..d` to both `act` and `pend`, and `pend_valid` stays 0.
- **Scan (`en`=1):**
  - When `cnt`<DIV-1, `cnt` increments.
  - When `cnt`==DIV-1 (slot end), `cnt` returns to 0 and `sel` advances by 1, wrapping 3→0.
- **Frame boundary:** this is the slot end with `sel`==3.
  - `frame_done` is set for the next cycle.
  - If `load`=1 on the same cycle, `act` takes `a..d` directly.
  - Otherwise, if `pend_valid`=1, `act` takes `pend`.
  - `pend_valid` clears in both cases.
- **Load during scan, not at a frame boundary:** `pend` takes `a..d` and `pend_valid` is set. A later load before the boundary overwrites `pend`; the newest load wins.
- **Enables:** `en_x` = (`sel`==x) & (`cnt`>=BLANK). This is combinational from registered state only, so it is glitch-free relative to `clk`.
  - At most one enable is high at any time.
  - All enables are 0 while `cnt`<BLANK, which includes the whole of idle because BLANK>=1.
- **`digit`:** `act[sel]`, combinational from registers.
- **Reset mid-scan:** everything returns to reset values immediately. The `pend` contents are lost.

## Timing
- Slot = DIV cycles; frame = 4·DIV cycles; each digit is lit DIV−BLANK cycles per frame.
- **Start of scan:** `en` is sampled 1 at edge t0 with `cnt`=0. At edge t0+k, `cnt`=k.
  - `en_a` first rises after edge t0+BLANK−1, i.e. the cycle in which `cnt`=BLANK.
- **Stop of scan:** `en` is sampled 0 at edge t. `cnt`=0 and `sel`=0 after edge t, so all enables are low in the next cycle. The turn-off latency is 1 edge.
- **Load latency:**
  - Values become visible on `digit` at the first frame boundary following the load edge. That is at most 4·DIV cycles later.
  - When the load coincides with the boundary edge itself, they are visible on that boundary.
- **`frame_done`:** high for exactly one cycle, coincident with `sel`=0, `cnt`=0 after the wrap. It is never asserted in idle.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-cycle during scan → all outputs read 0 immediately. Release with `en`=1, DIV=4, BLANK=1 → `en_a` is high when `cnt`=1..3, then `en_b` 4 cycles later, and so on. The `sel` sequence is 0,1,2,3,0, with 4 cycles per value.
- **Idle load:** `en`=0, load a..d = 1,2,3,4 → next cycle `act`=1,2,3,4 and `pend_valid`=0. Enable `en` → `digit` reads 1,2,3,4 across the slots; `frame_done` pulses every 16 cycles.
- **Atomic update:** scanning with `act`=1,2,3,4, load 9,8,7,6 while `sel`=1 → `pend_valid`=1 and `digit` stays at 2, 3, 4 for the rest of the frame. After the wrap, `digit`=9 with `sel`=0, `frame_done`=1 and `pend_valid`=0.
- **Collisions:**
  - Load 5,5,5,5 then load 6,6,6,6 in the same frame → the next frame shows 6,6,6,6.
  - Load 7,7,7,7 exactly on the edge where `sel`=3 and `cnt`=3 → `act`=7,7,7,7 on that wrap.
- **Blanking and exclusivity:** over 1000 random cycles with random `en`/`load`, DIV=5, BLANK=2 → the enables are never more than one-hot. No enable is high when `cnt`<2. Dropping `en` gives all enables 0 from the following cycle.
